imem_loader: RTL and testbench

//  Boot-time writer for the byte-addressed instruction memory. Accepts a framed byte

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   I_MEM_SIZE      default instruction memory size in bytes (power of two)
//   LDR_HDR_BYTES   number of little-endian length bytes that open a frame
//   ldr_state_e     loader FSM state encoding
//   ldr_accepts()   true for states in which the loader takes host bytes
package imem_loader_pkg;

  localparam int unsigned I_MEM_SIZE    = 1024;
  localparam int unsigned LDR_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHdr     = 3'd1,
    StPayload = 3'd2,
    StChk     = 3'd3,
    StDone    = 3'd4,
    StErr     = 3'd5
  } ldr_state_e;

  function automatic logic ldr_accepts(input ldr_state_e st);
    return (st == StHdr) || (st == StPayload) || (st == StChk);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time writer for the byte-addressed instruction memory.
// Consumes a framed byte stream: 4-byte length L (LSB first), L payload bytes,
// one XOR checksum byte. Payload byte n is written to address n one cycle after
// it is accepted. The core is held in reset until a frame is loaded and verified.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 one-cycle pulse, begins a load from IDLE/DONE/ERR
//   i_rx_valid, i_rx_data   host byte stream
//   o_rx_ready              registered; high while in HDR/PAYLOAD/CHK
//   o_we, o_waddr, o_wdata  byte-wide memory write port
//   o_busy, o_done, o_err   status (done/err sticky until next start)
//   o_cpu_rst_n             core reset, released only in DONE
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE = I_MEM_SIZE,
  parameter int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [7:0]        o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_cpu_rst_n
);

  localparam logic [1:0] HdrLastIdx = 2'(LDR_HDR_BYTES - 1);

  ldr_state_e        r_state, w_state_nxt;
  logic [1:0]        r_hdr_idx, w_hdr_idx_nxt;
  logic [31:0]       r_len, w_len_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
  logic [7:0]        r_xor, w_xor_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic              r_rx_ready, r_busy, r_done, r_err, r_cpu_rst_n;

  logic              w_xfer;
  logic [31:0]       w_hdr_len;
  logic [31:0]       w_cnt_inc;

  assign w_xfer    = i_rx_valid & r_rx_ready;
  assign w_cnt_inc = 32'(r_cnt) + 32'd1;

  // Length with the current header byte merged in; only meaningful in HDR.
  always_comb begin
    w_hdr_len = r_len;
    w_hdr_len[{r_hdr_idx, 3'b000} +: 8] = i_rx_data;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_idx_nxt = r_hdr_idx;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_xor_nxt     = r_xor;
    w_we_nxt      = 1'b0;
    w_waddr_nxt   = r_waddr;
    w_wdata_nxt   = r_wdata;

    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (i_start) begin
          w_state_nxt   = StHdr;
          w_hdr_idx_nxt = '0;
          w_len_nxt     = '0;
          w_cnt_nxt     = '0;
          w_xor_nxt     = '0;
        end
      end
      StHdr: begin
        if (w_xfer) begin
          w_len_nxt     = w_hdr_len;
          w_hdr_idx_nxt = r_hdr_idx + 2'd1;
          if (r_hdr_idx == HdrLastIdx) begin
            // Full 32-bit compare: L == MEM_SIZE is legal, anything larger is not.
            if (w_hdr_len > MEM_SIZE)   w_state_nxt = StErr;
            else if (w_hdr_len == '0)   w_state_nxt = StChk;
            else                        w_state_nxt = StPayload;
          end
        end
      end
      StPayload: begin
        if (w_xfer) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_cnt[ADDR_W-1:0];
          w_wdata_nxt = i_rx_data;
          w_xor_nxt   = r_xor ^ i_rx_data;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (w_cnt_inc == r_len) w_state_nxt = StChk;
        end
      end
      StChk: begin
        if (w_xfer) begin
          w_state_nxt = (i_rx_data == r_xor) ? StDone : StErr;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status flags are registered from the next state so they switch with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hdr_idx   <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_xor       <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_hdr_idx   <= w_hdr_idx_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_xor       <= w_xor_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rx_ready  <= ldr_accepts(w_state_nxt);
      r_busy      <= ldr_accepts(w_state_nxt);
      r_done      <= (w_state_nxt == StDone);
      r_err       <= (w_state_nxt == StErr);
      r_cpu_rst_n <= (w_state_nxt == StDone);
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cpu_rst_n = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected memory writes are queued as
// payload bytes are driven and compared as the write port produces them.
module tb_imem_loader;

  localparam int unsigned MemSize = 64;
  localparam int unsigned AddrW   = 6;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic             i_rx_valid;
  logic [7:0]       i_rx_data;
  logic             o_rx_ready;
  logic             o_we;
  logic [AddrW-1:0] o_waddr;
  logic [7:0]       o_wdata;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic             o_cpu_rst_n;

  imem_loader #(
    .MEM_SIZE (MemSize),
    .ADDR_W   (AddrW)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_cpu_rst_n (o_cpu_rst_n)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int exp_addr[$];
  int exp_data[$];
  logic [7:0] pl[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every o_we pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n && o_we) begin
      n_writes++;
      if (exp_addr.size() == 0) begin
        check_eq("unexpected_write", 32'(o_waddr), 32'hFFFF_FFFF);
      end else begin
        check_eq("waddr", 32'(o_waddr), 32'(exp_addr.pop_front()));
        check_eq("wdata", 32'(o_wdata), 32'(exp_data.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) tick();
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_rx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check_eq("rx_ready_timeout", 32'd0, 32'd1);
    else     tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic start_load();
    pulse_start();
    check_eq("start_busy", 32'(o_busy), 32'd1);
    check_eq("start_done", 32'(o_done), 32'd0);
    check_eq("start_err", 32'(o_err), 32'd0);
    check_eq("start_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
    check_eq("start_ready", 32'(o_rx_ready), 32'd1);
  endtask

  // Sends header, payload from pl[] (queuing expected writes) and checksum.
  // start_at >= 0 pulses i_start before that payload byte; it must be ignored.
  task automatic send_frame(input int unsigned len, input logic [7:0] chk_flip,
                            input int max_gap, input int start_at);
    logic [7:0] x;
    logic [31:0] l;
    x = 8'h00;
    l = len;
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], $urandom_range(0, max_gap));
    if (len > MemSize) return;
    for (int i = 0; i < int'(len); i++) begin
      if (i == start_at) pulse_start();
      exp_addr.push_back(i);
      exp_data.push_back(int'(pl[i]));
      x = x ^ pl[i];
      send_byte(pl[i], $urandom_range(0, max_gap));
    end
    send_byte(x ^ chk_flip, $urandom_range(0, max_gap));
  endtask

  task automatic expect_end(input string tag, input logic done, input int writes0,
                            input int nw);
    tick();
    check_eq({tag, "_done"}, 32'(o_done), 32'(done));
    check_eq({tag, "_err"}, 32'(o_err), 32'(!done));
    check_eq({tag, "_cpu_rst_n"}, 32'(o_cpu_rst_n), 32'(done));
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
    check_eq({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    check_eq({tag, "_nwrites"}, 32'(n_writes - writes0), 32'(nw));
  endtask

  task automatic load_test1();
    pl.delete();
    pl.push_back(8'h13); pl.push_back(8'h00); pl.push_back(8'h00); pl.push_back(8'h00);
    pl.push_back(8'h93); pl.push_back(8'h00); pl.push_back(8'h10); pl.push_back(8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, 32'(o_we), 32'd0);
    check_eq({tag, "_waddr"}, 32'(o_waddr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(o_wdata), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_err"}, 32'(o_err), 32'd0);
    check_eq({tag, "_cpu_rst_n"}, 32'(o_cpu_rst_n), 32'd0);
    check_eq({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
  endtask

  initial begin
    int w0;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();
    // Bytes offered in IDLE are not taken.
    i_rx_valid = 1'b1;
    tick();
    check_eq("idle_ready", 32'(o_rx_ready), 32'd0);
    i_rx_valid = 1'b0;

    // 1: good 8-byte image (checksum 0x90).
    load_test1();
    w0 = n_writes;
    start_load();
    send_frame(8, 8'h00, 0, -1);
    expect_end("t1", 1'b1, w0, 8);

    // 2: bad checksum, writes still happen.
    w0 = n_writes;
    start_load();
    send_frame(8, 8'h01, 0, -1);
    expect_end("t2", 1'b0, w0, 8);

    // 3: empty images.
    w0 = n_writes;
    start_load();
    send_frame(0, 8'h00, 0, -1);
    expect_end("t3a", 1'b1, w0, 0);
    w0 = n_writes;
    start_load();
    send_frame(0, 8'h01, 0, -1);
    expect_end("t3b", 1'b0, w0, 0);

    // 4a: oversize length rejected right after the header.
    w0 = n_writes;
    start_load();
    send_frame(MemSize + 1, 8'h00, 0, -1);
    check_eq("t4a_err", 32'(o_err), 32'd1);
    check_eq("t4a_ready", 32'(o_rx_ready), 32'd0);
    expect_end("t4a", 1'b0, w0, 0);

    // 4b: image fills memory exactly.
    pl.delete();
    for (int i = 0; i < int'(MemSize); i++) pl.push_back(8'($urandom));
    w0 = n_writes;
    start_load();
    send_frame(MemSize, 8'h00, 0, -1);
    check_eq("t4b_last_addr", 32'(o_waddr), MemSize - 1);
    expect_end("t4b", 1'b1, w0, MemSize);

    // 5: test 1 with random valid gaps.
    load_test1();
    w0 = n_writes;
    start_load();
    send_frame(8, 8'h00, 3, -1);
    expect_end("t5", 1'b1, w0, 8);

    // 6: reset mid-payload, then a clean reload with a stray i_start.
    start_load();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(int'(pl[i]));
      send_byte(pl[i], 0);
    end
    i_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    exp_addr.delete();
    exp_data.delete();
    tick();
    i_rst_n = 1'b1;
    tick();
    w0 = n_writes;
    start_load();
    send_frame(8, 8'h00, 1, 3);
    expect_end("t6", 1'b1, w0, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
